button_ud_pulser: RTL and testbench
===================================

Name: button_ud_pulser

Overview:
- Upstream front end for the up/down counter.
- Takes the two raw board pushbuttons and turns each one into a clean, single-cycle up or down strobe. Each button goes through a synchroniser, a debounce FSM and a press-edge pulse generator.
- The up/down outputs connect directly to the counter's up/down inputs.
- Default timing targets the 12 MHz board clock.

Parameters:
- ACTIVE_LOW, 1, 1 means a raw button reads 0 when pressed; 0 means it reads 1 when pressed.
- DEB_CYCLES, 240000, number of consecutive stable synchronised samples needed to accept a press or a release (20 ms at 12 MHz). Must be ≥2.
- HOLD_CYCLES, 6000000, delay from the initial press pulse to the first auto-repeat pulse. Used only with AUTO_REPEAT_EN.
- REPEAT_CYCLES, 1200000, spacing between auto-repeat pulses. Used only with AUTO_REPEAT_EN.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, asynchronous, active-low reset: 0 resets, 1 runs.
- btn_up, input, 1, raw asynchronous up button.
- btn_down, input, 1, raw asynchronous down button.
- up, output, 1, one-cycle increment strobe; registered.
- down, output, 1, one-cycle decrement strobe; registered.
- up_held, output, 1, debounced pressed level of the up button.
- down_held, output, 1, debounced pressed level of the down button.

Behaviour:
- Reset, asynchronous on reset=0:
  - Synchroniser flops load the released level.
  - Both FSMs go to IDLE; all counters clear.
  - up, down, up_held, down_held are all 0.
  - After reset is released, nothing is emitted until a full debounce completes.
- Synchroniser:
  - Two flops per button. Polarity is normalised so that s=1 means pressed.
  - Counters are sized with $clog2 of the largest count used.
- Per-button FSM, four states:
  - IDLE: s=1 → go to WAIT_PRESS, cnt=0.
  - WAIT_PRESS: s=0 → return to IDLE. s=1 and cnt<DEB_CYCLES-1 → cnt+1. s=1 and cnt==DEB_CYCLES-1 → go to PRESSED and raise the internal pulse for one cycle.
  - PRESSED: s=0 → go to WAIT_RELEASE, cnt=0.
  - WAIT_RELEASE: s=1 → return to PRESSED with no pulse. s=0 and cnt==DEB_CYCLES-1 → go to IDLE. Otherwise cnt+1.
- Pulse rules:
  - No pulse is ever generated on release.
  - A held button produces exactly one pulse (auto-repeat excepted).
- Held outputs: x_held=1 exactly while the FSM is in PRESSED or WAIT_RELEASE.
- Latency:
  - Let edge k be the first edge at which the raw input is sampled pressed and stays pressed.
  - The output pulse is high in the cycle after edge k+DEB_CYCLES+2, i.e. DEB_CYCLES+2 cycles after press.
  - Pulse width is exactly 1 cycle.
- Bounce: any reversion of s during WAIT_PRESS restarts qualification from IDLE. A glitch shorter than DEB_CYCLES never produces a pulse.
- Simultaneous pulses:
  - If both internal pulses assert in the same cycle, both up and down are 0 that cycle. The counter therefore never sees up and down together.
  - Pulses in different cycles pass through independently, including while the other button is held.
- Reset mid-operation: any state is abandoned immediately, and any in-flight pulse is dropped.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- When defined:
  - In PRESSED, a repeat counter runs.
  - The first extra pulse occurs HOLD_CYCLES cycles after the initial pulse; further pulses follow every REPEAT_CYCLES cycles while the FSM remains in PRESSED.
  - Entering WAIT_RELEASE clears the repeat counter and resumes nothing on return. Re-entry to PRESSED from WAIT_RELEASE restarts the HOLD_CYCLES wait.
  - Repeat pulses obey the simultaneous-cancel rule.
- When undefined: the repeat counter and its logic are absent, HOLD_CYCLES and REPEAT_CYCLES are ignored, and there is exactly one pulse per accepted press.

Test Plan (ACTIVE_LOW=1, DEB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3):
- reset=0 asserted at an arbitrary point during a WAIT_PRESS qualification → all outputs 0 immediately. Release reset with btn_up still 0 → up pulses exactly 6 cycles later, once.
- btn_up driven 0 at edge k and held for 20 cycles, then released → up=1 only in the cycle after edge k+6. up_held=1 from k+6 until 4 stable-release samples later. down stays 0 throughout.
- btn_down toggled every 2 cycles for 12 cycles, then held 0 → no pulse during the toggling. Exactly one down pulse 6 cycles after the final stable low.
- btn_up pulsed low for 3 cycles only → no up pulse and up_held stays 0.
- btn_up and btn_down both driven 0 at the same edge → up=down=0 in every cycle. Both up_held and down_held rise together at k+6.
- btn_up held for 30 cycles:
  - With AUTO_REPEAT_EN: up pulses at k+6, k+16, k+19, k+22, k+25, k+28.
  - Without AUTO_REPEAT_EN: only the k+6 pulse.

Source files
------------

// File: rtl/button_ud_pulser.sv
// rtl/button_ud_pulser.sv - two-button synchronise/debounce/press-pulse front end for the up/down counter
// Optional hold-to-repeat pulses are enabled by defining AUTO_REPEAT_EN.
module button_ud_pulser #(
  parameter int ACTIVE_LOW    = 1,
  parameter int DEB_CYCLES    = 240000,
  parameter int HOLD_CYCLES   = 6000000,
  parameter int REPEAT_CYCLES = 1200000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic up,
  output logic down,
  output logic up_held,
  output logic down_held
);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;

`ifdef AUTO_REPEAT_EN
  localparam int MAX_DH    = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
  localparam int MAX_COUNT = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
`else
  localparam int MAX_COUNT = DEB_CYCLES;
`endif
  localparam int CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  // Index 0 is the up button, index 1 the down button; 1 always means pressed.
  logic [1:0] raw_pressed;
  logic [1:0] meta_q;
  logic [1:0] s_q;

  assign raw_pressed = (ACTIVE_LOW != 0) ? ~{btn_down, btn_up} : {btn_down, btn_up};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      s_q    <= '0;
    end else begin
      meta_q <= raw_pressed;
      s_q    <= meta_q;
    end
  end

  state_t        state_q [2];
  state_t        state_d [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];
  logic [1:0]    press_pulse;
  logic [1:0]    fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    press_pulse = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (s_q[i]) begin
            state_d[i] = WAIT_PRESS;
            cnt_d[i]   = '0;
          end
        end
        WAIT_PRESS: begin
          if (!s_q[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i]     = PRESSED;
            press_pulse[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        PRESSED: begin
          if (!s_q[i]) begin
            state_d[i] = WAIT_RELEASE;
            cnt_d[i]   = '0;
          end
        end
        WAIT_RELEASE: begin
          // A bounce back to pressed resumes the held state silently.
          if (s_q[i]) begin
            state_d[i] = PRESSED;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  logic [CW-1:0] rcnt_q [2];
  logic [CW-1:0] rcnt_d [2];
  logic [1:0]    rep_phase_q;
  logic [1:0]    rep_phase_d;
  logic [1:0]    rep_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_phase_q <= '0;
      for (int i = 0; i < 2; i++) rcnt_q[i] <= '0;
    end else begin
      rep_phase_q <= rep_phase_d;
      for (int i = 0; i < 2; i++) rcnt_q[i] <= rcnt_d[i];
    end
  end

  // First wait is HOLD_CYCLES, then every REPEAT_CYCLES; any other state restarts it.
  always_comb begin
    rep_pulse   = '0;
    rep_phase_d = '0;
    for (int i = 0; i < 2; i++) begin
      rcnt_d[i] = '0;
      if (state_q[i] == PRESSED && s_q[i]) begin
        if (rep_phase_q[i] ? (rcnt_q[i] == REP_LAST) : (rcnt_q[i] == HOLD_LAST)) begin
          rep_pulse[i]   = 1'b1;
          rep_phase_d[i] = 1'b1;
        end else begin
          rcnt_d[i]      = rcnt_q[i] + 1'b1;
          rep_phase_d[i] = rep_phase_q[i];
        end
      end
    end
  end

  assign fire = press_pulse | rep_pulse;
`else
  // Repeat timing has no effect in this build.
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_repeat_cfg_inert
  end

  assign fire = press_pulse;
`endif

  // Coincident strobes cancel so the counter never sees up and down together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up   <= 1'b0;
      down <= 1'b0;
    end else begin
      up   <= fire[0] & ~fire[1];
      down <= fire[1] & ~fire[0];
    end
  end

  assign up_held   = (state_q[0] == PRESSED) || (state_q[0] == WAIT_RELEASE);
  assign down_held = (state_q[1] == PRESSED) || (state_q[1] == WAIT_RELEASE);

endmodule

// File: tb/tb_button_ud_pulser.sv
// tb/tb_button_ud_pulser.sv - scoreboard bench for button_ud_pulser with directed and random button traffic
module tb_button_ud_pulser;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic reset;
  logic btn_up;
  logic btn_down;
  logic up;
  logic down;
  logic up_held;
  logic down_held;

  always #5 clk = ~clk;

  button_ud_pulser #(
    .ACTIVE_LOW(1),
    .DEB_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .up(up),
    .down(down),
    .up_held(up_held),
    .down_held(down_held)
  );

  typedef struct packed {
    logic up;
    logic down;
    logic up_held;
    logic down_held;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model: two-sample input delay, then a level that flips after
  // DEB+1 consecutive disagreeing samples; a flip to pressed emits a pulse.
  bit [1:0] h1, h2, lvl;
  int run [2];
  int t   [2];

  always @(posedge clk) begin
    bit [1:0] s;
    bit [1:0] p;
    exp_t e;
    cycle++;
    e = '0;
    if (!reset) begin
      h1 = '0; h2 = '0; lvl = '0;
      run = '{0, 0};
      t = '{0, 0};
    end else begin
      s  = h2;
      h2 = h1;
      h1 = ~{btn_down, btn_up};
      p  = '0;
      for (int b = 0; b < 2; b++) begin
        if (s[b] != lvl[b]) begin
          run[b]++;
          t[b] = 0;
          if (run[b] == DEB + 1) begin
            lvl[b] = s[b];
            run[b] = 0;
            p[b]   = s[b];
          end
        end else begin
          if (lvl[b] && run[b] == 0) begin
            t[b]++;
`ifdef AUTO_REPEAT_EN
            if (t[b] == HOLD || (t[b] > HOLD && (t[b] - HOLD) % REP == 0)) p[b] = 1'b1;
`endif
          end
          run[b] = 0;
        end
      end
      e.up        = p[0] & ~p[1];
      e.down      = p[1] & ~p[0];
      e.up_held   = lvl[0];
      e.down_held = lvl[1];
    end
    exp_q.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    #1;
    a = {up, down, up_held, down_held};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty cycle %0d: got %b with no expected entry", cycle, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard cycle %0d: up/down/up_held/down_held got %b expected %b", cycle, a, e);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Bit i of a pattern is the pressed state seen at edge k+i; bit i of a result is sampled after edge k+i.
  task automatic run_pattern(input logic [63:0] up_pat, input logic [63:0] dn_pat, input int win,
                             output logic [63:0] up_v, output logic [63:0] dn_v,
                             output logic [63:0] uh_v, output logic [63:0] dh_v);
    up_v = '0; dn_v = '0; uh_v = '0; dh_v = '0;
    for (int i = 0; i < win; i++) begin
      @(negedge clk);
      btn_up   = ~up_pat[i];
      btn_down = ~dn_pat[i];
      @(posedge clk);
      #1;
      up_v[i] = up;
      dn_v[i] = down;
      uh_v[i] = up_held;
      dh_v[i] = down_held;
    end
    @(negedge clk);
    btn_up   = 1'b1;
    btn_down = 1'b1;
  endtask

  logic [63:0] up_v, dn_v, uh_v, dh_v, pat, none;
  logic [63:0] exp_rep;

  initial begin
    none     = '0;
    reset    = 1'b0;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {60'd0, up, down, up_held, down_held}, 64'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Single press held 20 cycles.
    run_pattern(rng(0, 19), none, 40, up_v, dn_v, uh_v, dh_v);
    chk("press_up_pulse", up_v, 64'd1 << 6);
    chk("press_up_held", uh_v, rng(6, 25));
    chk("press_down_quiet", dn_v, none);

    // Down button bounces, then settles pressed from edge 12.
    pat = rng(12, 29);
    for (int i = 0; i < 12; i++) pat[i] = ((i / 2) % 2 == 0);
    run_pattern(none, pat, 45, up_v, dn_v, uh_v, dh_v);
    chk("bounce_down_pulse", dn_v, 64'd1 << 18);
    chk("bounce_up_quiet", up_v, none);

    // Short glitch.
    run_pattern(rng(0, 2), none, 20, up_v, dn_v, uh_v, dh_v);
    chk("glitch_no_pulse", up_v, none);
    chk("glitch_no_held", uh_v, none);

    // Simultaneous press cancels both strobes.
    run_pattern(rng(0, 19), rng(0, 19), 40, up_v, dn_v, uh_v, dh_v);
    chk("simul_up_cancel", up_v, none);
    chk("simul_down_cancel", dn_v, none);
    chk("simul_up_held", uh_v, rng(6, 25));
    chk("simul_down_held", dh_v, rng(6, 25));

    // Long hold.
    run_pattern(rng(0, 29), none, 45, up_v, dn_v, uh_v, dh_v);
`ifdef AUTO_REPEAT_EN
    exp_rep = '0;
    exp_rep[6] = 1'b1; exp_rep[16] = 1'b1; exp_rep[19] = 1'b1;
    exp_rep[22] = 1'b1; exp_rep[25] = 1'b1; exp_rep[28] = 1'b1;
`else
    exp_rep = 64'd1 << 6;
`endif
    chk("hold_up_pulses", up_v & rng(0, 29), exp_rep);

    // Reset during press qualification, button kept pressed across reset.
    @(negedge clk);
    btn_up = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_in_wait_press", {60'd0, up, down, up_held, down_held}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    up_v = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      up_v[i] = up;
    end
    chk("after_reset_pulse", up_v, 64'd1 << 6);
    @(negedge clk);
    btn_up = 1'b1;
    repeat (15) @(negedge clk);

    // Reset while a pulse is in flight and the button is held.
    btn_up = 1'b0;
    for (int i = 0; i < 20 && !up_held; i++) begin
      @(posedge clk);
      #1;
    end
    chk("held_before_reset", {63'd0, up_held}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_drops_state", {60'd0, up, down, up_held, down_held}, 64'd0);
    btn_up = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Random traffic, checked by the scoreboard.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom % 6 == 0) btn_up = ~btn_up;
      if ($urandom % 6 == 0) btn_down = ~btn_down;
      if ($urandom % 700 == 0) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b1;
      end
    end
    btn_up   = 1'b1;
    btn_down = 1'b1;
    repeat (40) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
